// File: rtl/joy_db15_tx_if.sv
// DB15 serial joystick link pins: shift clock, parallel load, serial data.
// master = reader side (drives JOY_CLK/JOY_LOAD), slave = device side (drives JOY_DATA).
interface joy_db15_tx_if;
    logic JOY_CLK;
    logic JOY_LOAD;
    logic JOY_DATA;

    modport master (
        output JOY_CLK,
        output JOY_LOAD,
        input  JOY_DATA
    );

    modport slave (
        input  JOY_CLK,
        input  JOY_LOAD,
        output JOY_DATA
    );
endinterface

// File: rtl/joy_db15_tx.sv
// Device end of the SNAC DB15 serial joystick link (74HC165 chain emulation).
// Latches two player button words while JOY_LOAD is low and shifts them out
// LSB first (j1[0]..j1[N-1], j2[0]..j2[N-1]) on each JOY_CLK rising edge.
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   joystick1, joystick2  button words, active-high
//   link (slave)          JOY_CLK/JOY_LOAD in (async), JOY_DATA out (active-low)
//   busy                  high while a frame is being shifted
//   frame_done            1-clk pulse on the last shift of a frame
//   frame_err             1-clk pulse on a short frame
// Optional: define JOY_DB15_TX_FRAMECHK_EN to enable short-frame detection
// and an 8-bit saturating error counter; otherwise frame_err is tied 0.
module joy_db15_tx #(
    parameter int NBITS       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NBITS-1:0] joystick1,
    input  logic [NBITS-1:0] joystick2,
    joy_db15_tx_if.slave     link,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int FRAME = 2 * NBITS;
    localparam int CW    = $clog2(FRAME + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   clk_d;
    logic                   clk_s;
    logic                   load_s;
    logic                   clk_rise;
    logic                   do_load;
    logic                   do_shift;

    logic [FRAME-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             data_q;
    logic             done_q;
    logic             done_nxt;

    // Synchronisers reset to 1 so a released pin never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            load_sync <= '1;
            clk_d     <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], link.JOY_CLK};
            load_sync <= {load_sync[SYNC_STAGES-2:0], link.JOY_LOAD};
            clk_d     <= clk_s;
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign load_s   = load_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_d;

    // Load has priority: a clock edge while load is low is ignored.
    assign do_load  = ~load_s;
    assign do_shift = clk_rise & load_s;

    // Ones shift in from the top, so overclocking reports "released".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '1;
            cnt <= '0;
        end else if (do_load) begin
            sr  <= {~joystick2, ~joystick1};
            cnt <= '0;
        end else if (do_shift) begin
            sr  <= {1'b1, sr[FRAME-1:1]};
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= 1'b1;
        end else begin
            data_q <= sr[0];
        end
    end

    assign link.JOY_DATA = data_q;

`ifdef JOY_DB15_TX_FRAMECHK_EN
    logic       err_nxt;
    logic       err_q;
    logic [7:0] err_count;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
`ifdef JOY_DB15_TX_FRAMECHK_EN
        err_nxt   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (do_load) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (load_s) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (do_load) begin
                    state_nxt = LOAD;
`ifdef JOY_DB15_TX_FRAMECHK_EN
                    // cnt never reaches FRAME inside SHIFT.
                    err_nxt = (cnt != '0);
`endif
                end else if (do_shift && cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                if (do_load) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered so the pulse coincides with the last shift of sr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_nxt;
        end
    end

    assign busy       = (state == SHIFT);
    assign frame_done = done_q;

`ifdef JOY_DB15_TX_FRAMECHK_EN
    // Sticky debug counter of short frames, saturating at 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q     <= 1'b0;
            err_count <= '0;
        end else begin
            err_q <= err_nxt;
            if (err_nxt && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: reset, full frame, overclock, short frame,
// load/clock race and mid-frame reset, against hand-computed bit values.
module tb_joy_db15_tx;

    localparam int HALF = 20;

    logic        clk;
    logic        reset_n;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    int n_checks;
    int n_errors;
    int done_cnt;
    int err_cnt;

    joy_db15_tx_if link ();

    joy_db15_tx #(
        .NBITS      (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .link      (link.slave),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_pulse();
        link.JOY_LOAD = 1'b0;
        wait_clk(HALF);
        link.JOY_LOAD = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic clk_pulse();
        link.JOY_CLK = 1'b1;
        wait_clk(HALF);
        link.JOY_CLK = 1'b0;
        wait_clk(HALF);
    endtask

    initial begin
        logic [31:0] fr;
        int          d0;
        int          e0;
        int          ferr;

        n_checks  = 0;
        n_errors  = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        joystick1 = 16'h0000;
        joystick2 = 16'h0000;
        link.JOY_CLK  = 1'b0;
        link.JOY_LOAD = 1'b1;
        reset_n   = 1'b0;
`ifdef JOY_DB15_TX_FRAMECHK_EN
        ferr = 1;
`else
        ferr = 0;
`endif

        // 1: reset state, then idle with no stimulus
        wait_clk(3);
        check("rst_data", 32'(link.JOY_DATA), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        wait_clk(50);
        check("idle_data", 32'(link.JOY_DATA), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done_cnt", 32'(done_cnt), 32'd0);

        // 2: full frame, bits 0,1x30,0
        joystick1 = 16'h0001;
        joystick2 = 16'h8000;
        fr = 32'h7FFF_FFFE;
        d0 = done_cnt;
        load_pulse();
        check("f_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("f_bit%0d", i), 32'(link.JOY_DATA), 32'(fr[i]));
            if (i == 31) begin
                check("f_busy_last", 32'(busy), 32'd1);
                check("f_no_early_done", 32'(done_cnt - d0), 32'd0);
            end
            clk_pulse();
        end
        check("f_done_once", 32'(done_cnt - d0), 32'd1);
        check("f_busy_end", 32'(busy), 32'd0);
        check("f_tail", 32'(link.JOY_DATA), 32'd1);

        // 3: overclock, 40 clocks of all-released
        joystick1 = 16'h0000;
        joystick2 = 16'h0000;
        d0 = done_cnt;
        load_pulse();
        for (int i = 0; i < 40; i++) begin
            check($sformatf("oc_bit%0d", i), 32'(link.JOY_DATA), 32'd1);
            clk_pulse();
        end
        check("oc_done_once", 32'(done_cnt - d0), 32'd1);
        check("oc_busy", 32'(busy), 32'd0);

        // 4: short frame, reload after 10 clocks
        load_pulse();
        for (int i = 0; i < 10; i++) clk_pulse();
        joystick1 = 16'h0006;
        e0 = err_cnt;
        d0 = done_cnt;
        load_pulse();
        check("sf_err", 32'(err_cnt - e0), 32'(ferr));
        check("sf_no_done", 32'(done_cnt - d0), 32'd0);
        check("sf_busy", 32'(busy), 32'd1);
        check("sf_bit0", 32'(link.JOY_DATA), 32'd1);
        clk_pulse();
        check("sf_bit1", 32'(link.JOY_DATA), 32'd0);
        clk_pulse();
        check("sf_bit2", 32'(link.JOY_DATA), 32'd0);
        clk_pulse();
        check("sf_bit3", 32'(link.JOY_DATA), 32'd1);

        // 5: load falls with the clock rise
        joystick1 = 16'h0003;
        link.JOY_LOAD = 1'b0;
        link.JOY_CLK  = 1'b1;
        wait_clk(HALF);
        link.JOY_LOAD = 1'b1;
        wait_clk(HALF);
        check("race_bit0", 32'(link.JOY_DATA), 32'd0);
        link.JOY_CLK = 1'b0;
        wait_clk(HALF);
        check("race_hold", 32'(link.JOY_DATA), 32'd0);
        clk_pulse();
        check("race_bit1", 32'(link.JOY_DATA), 32'd0);
        clk_pulse();
        check("race_bit2", 32'(link.JOY_DATA), 32'd1);

        // 6: reset mid-frame
        joystick1 = 16'hFFFF;
        joystick2 = 16'hFFFF;
        load_pulse();
        for (int i = 0; i < 12; i++) clk_pulse();
        check("mr_pre_data", 32'(link.JOY_DATA), 32'd0);
        check("mr_pre_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        wait_clk(1);
        check("mr_data", 32'(link.JOY_DATA), 32'd1);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(frame_done), 32'd0);
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(10);
        clk_pulse();
        check("mr_post_data", 32'(link.JOY_DATA), 32'd1);
        check("mr_post_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
